// File: rtl/conv_unit_mlane.sv
// Multi-lane convolution unit: one output pixel of a D x F x F window per bundle,
// LANES parallel signed MACs, lane-sum reduction, bias, optional ReLU and saturation.
//
// state  | meaning
// IDLE   | waiting for an operand bundle (in_ready high)
// ACCUM  | K steps, each lane multiplies-accumulates one element per step
// REDUCE | sum lanes, rescale, add bias, ReLU, saturate into result
// HOLD   | result presented until the consumer takes it
module conv_unit_mlane #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int D          = 1,
  parameter int F          = 5,
  parameter int LANES      = 5,
  parameter int FRAC_BITS  = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [0:D*F*F*DATA_WIDTH-1]       image,
  input  logic [0:D*F*F*DATA_WIDTH-1]       filter,
  input  logic [DATA_WIDTH-1:0]             bias,
  input  logic                              relu_en,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             result,
  output logic                              busy
);

  localparam int N  = D * F * F;
  localparam int K  = (N + LANES - 1) / LANES;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int VW = N * DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] MAX_V =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN_V =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_REDUCE, S_HOLD} state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [0:VW-1]                image_q, image_d;
  logic [0:VW-1]                filter_q, filter_d;
  logic [DATA_WIDTH-1:0]        bias_q, bias_d;
  logic                         relu_q, relu_d;
  logic signed [ACC_WIDTH-1:0]  acc_q [LANES];
  logic signed [ACC_WIDTH-1:0]  acc_d [LANES];
  logic [DATA_WIDTH-1:0]        result_q, result_d;

  logic signed [PW-1:0]         prod [LANES];
  logic signed [ACC_WIDTH-1:0]  sum, scaled, biased, sat;

  // Operands shift toward element 0 each step, so lane l always reads slot l
  // and the zero fill provides the padding for the last partial step.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod[l] = $signed(image_q[DATA_WIDTH*l +: DATA_WIDTH]) *
                $signed(filter_q[DATA_WIDTH*l +: DATA_WIDTH]);
    end
  end

  always_comb begin
    sum = '0;
    for (int l = 0; l < LANES; l++) begin
      sum = sum + acc_q[l];
    end
    scaled = sum >>> FRAC_BITS;
    biased = scaled + {{(ACC_WIDTH-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q};
    if (relu_q && biased[ACC_WIDTH-1]) begin
      biased = '0;
    end
    if (biased > MAX_V) begin
      sat = MAX_V;
    end else if (biased < MIN_V) begin
      sat = MIN_V;
    end else begin
      sat = biased;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    image_d  = image_q;
    filter_d = filter_q;
    bias_d   = bias_q;
    relu_d   = relu_q;
    result_d = result_q;
    for (int l = 0; l < LANES; l++) begin
      acc_d[l] = acc_q[l];
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          image_d  = image;
          filter_d = filter;
          bias_d   = bias;
          relu_d   = relu_en;
          cnt_d    = CW'(K - 1);
          for (int l = 0; l < LANES; l++) begin
            acc_d[l] = '0;
          end
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        for (int l = 0; l < LANES; l++) begin
          acc_d[l] = acc_q[l] + {{(ACC_WIDTH-PW){prod[l][PW-1]}}, prod[l]};
        end
        image_d  = image_q << (LANES * DATA_WIDTH);
        filter_d = filter_q << (LANES * DATA_WIDTH);
        if (cnt_q == '0) begin
          state_d = S_REDUCE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_REDUCE: begin
        result_d = sat[DATA_WIDTH-1:0];
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      image_q  <= '0;
      filter_q <= '0;
      bias_q   <= '0;
      relu_q   <= 1'b0;
      result_q <= '0;
      for (int l = 0; l < LANES; l++) begin
        acc_q[l] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      image_q  <= image_d;
      filter_q <= filter_d;
      bias_q   <= bias_d;
      relu_q   <= relu_d;
      result_q <= result_d;
      for (int l = 0; l < LANES; l++) begin
        acc_q[l] <= acc_d[l];
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;

endmodule

// File: doc/conv_unit_mlane.md
Name: conv_unit_mlane

Overview:
- Multi-lane, handshaked successor to the single-PE sequential convolution unit.
- Computes one output pixel of a D×F×F window: dot product of image and filter, plus bias, optional ReLU, saturation.
- Uses LANES parallel signed fixed-point MACs instead of one MAC per cycle.
- Sits between the window/line-buffer feeder and the output-feature-map writer; valid/ready on both sides.

Parameters:
- DATA_WIDTH, 16: signed two's-complement operand/result width.
- ACC_WIDTH, 40: per-lane and reduction accumulator width (≥ 2*DATA_WIDTH + clog2(N)).
- D, 1: filter depth (channels).
- F, 5: filter side.
- LANES, 5: parallel MACs, 1..N. Need not divide N.
- FRAC_BITS, 8: fractional bits of the Q format, applied to the product sum.
- Derived: N = D*F*F; K = ceil(N/LANES).

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  operand bundle valid
- in_ready  out  1  unit can accept a bundle
- image  in  N*DATA_WIDTH  packed window; element i at [DATA_WIDTH*i +: DATA_WIDTH], element 0 at MSB end ([0:...] ordering)
- filter  in  N*DATA_WIDTH  packed weights, same ordering
- bias  in  DATA_WIDTH  signed bias in output Q format
- relu_en  in  1  apply ReLU to this bundle
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  DATA_WIDTH  saturated output pixel
- busy  out  1  high in any state except IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset (sampled high at an edge):
  - state=IDLE; in_ready=1; out_valid=0; result=0; busy=0.
  - Lane accumulators, step counter and captured operands cleared.
  - Overrides every other input, including reset mid-ACCUM, mid-REDUCE or in HOLD. The in-flight result is discarded and never presented.
- States: IDLE, ACCUM, REDUCE, HOLD.
  - in_ready = (state==IDLE); combinational from the state register.
- Accept:
  - At edge E0 with in_valid & in_ready, capture image, filter, bias, relu_en into internal registers.
  - Clear the accumulators, set step=0, go to ACCUM.
  - Inputs may change freely after E0.
- ACCUM: each edge, for step s and lane l, element i = s*LANES + l.
  - If i < N: acc_l += sign-extended(image_i * filter_i). Products are full 2*DATA_WIDTH signed.
  - If i ≥ N (padding in the last step): the lane contributes 0.
  - After step K-1 (K edges after E0), go to REDUCE.
- REDUCE: one edge.
  - sum = Σ acc_l (ACC_WIDTH, wraps modulo 2^ACC_WIDTH).
  - x = (sum >>> FRAC_BITS) + sign-extended bias.
  - If relu_en and x < 0, x = 0.
  - result = x clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Register result, set out_valid=1, go to HOLD.
- Latency: out_valid first high after edge E0+K+1. Default N=25, LANES=5, K=5, so 6 edges.
- HOLD:
  - result and out_valid stay stable while out_ready=0.
  - At an edge with out_ready=1: out_valid=0, state=IDLE. result keeps its last value.
  - in_ready rises the cycle after the handshake. No bypass from HOLD to accept, so throughput is one bundle per K+3 cycles.
- in_valid outside IDLE is ignored. The upstream must hold the bundle until in_ready.
- out_ready outside HOLD has no effect.
- LANES=1 degenerates to one MAC per cycle, K=N.

Test Plan:
- Defaults; image all 0x0100, filter all 0x0100, bias 0, relu_en 0, out_ready 1 → out_valid 6 edges after accept, result=0x1900 (25.0), pulse one cycle, in_ready back the following cycle.
- Defaults; image all 0x0100, filter all 0xFF00, bias 0x0080 → relu_en 0: result 0xE780 (-24.5); repeat with relu_en 1: result 0x0000.
- Defaults; image and filter all 0x7FFF → result 0x7FFF (positive saturation). Image 0x7FFF, filter 0x8000 → 0x8000.
- LANES=4, D=1, F=5 (K=7, padding); filter one-hot at element 24 = 0x0100, image element 24 = 0x0300, rest random → result 0x0300, out_valid 8 edges after accept.
- Backpressure: out_ready 0 for 10 cycles after out_valid → result/out_valid stable, in_ready 0 and in_valid ignored throughout. Then out_ready 1 → next bundle accepted 2 edges later with the correct result.
- Reset asserted for one edge at step 2 of ACCUM → next cycle state IDLE, out_valid 0, result 0, in_ready 1. New bundle then computes correctly with no residue from the aborted one.
